// File: rtl/rng_buffer.sv
// rng_buffer: samples the random source into a small FIFO at a programmable rate and serves it to the CPU.
// Optional feature: define RNG_WHITEN_EN to XOR each sample with the previous clock's input before storing.
module rng_buffer #(
    parameter int DEPTH      = 4,
    parameter int SAMPLE_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rnd_in,
    input  logic                       rd_en,
    output logic [7:0]                 d_out,
    output logic                       d_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [7:0]    d_out_q, d_out_d;
    logic          d_valid_q, d_valid_d;
    logic          err_q, err_d;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    sample;
    logic          tick;
    logic          push;
    logic          pop;

`ifdef RNG_WHITEN_EN
    logic [7:0]    prev_q, prev_d;

    assign prev_d = rnd_in;
    assign sample = rnd_in ^ prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 8'h00;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    assign sample = rnd_in;
`endif

    // Push and pop are both qualified by the registered flags, so neither sees a same-cycle effect of the other.
    assign tick = (div_q == DW'(SAMPLE_DIV - 1));
    assign push = tick && !full_q;
    assign pop  = rd_en && !empty_q;

    always_comb begin
        div_d     = div_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        d_out_d   = d_out_q;
        d_valid_d = 1'b0;
        err_d     = err_q;

        div_d = tick ? '0 : div_q + DW'(1);

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            d_out_d   = mem[rd_ptr_q];
            d_valid_d = 1'b1;
        end

        if (rd_en && empty_q) begin
            err_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            d_out_q   <= 8'h00;
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            err_q     <= err_d;
        end
    end

    // Storage has no reset so it can map onto RAM; pointers and count gate every access to it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= sample;
        end
    end

    assign d_out         = d_out_q;
    assign d_valid       = d_valid_q;
    assign empty         = empty_q;
    assign full          = full_q;
    assign count         = count_q;
    assign err_underflow = err_q;

endmodule
